regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  input  1  rising-edge clock shared with the register file.
- rst_n  input  1  asynchronous active-low reset.
REQ-002 The block SHALL provide two write requester ports, 0 (ALU) and 1 (load unit), per requester i:
- reqi_valid  input  1  write request present.
- reqi_rd  input  5  destination register.
- reqi_data  input  32  write data.
- reqi_ready  output  1  request accepted this cycle when valid&ready.
REQ-003 The block SHALL provide write port outputs wired to the register file:
- RegWrite  output  1  write enable.
- W1  output  5  write address.
- WD1  output  32  write data.
REQ-004 The block SHALL provide hazard query ports:
- R1, R2  input  5  register file read addresses.
- hazard1, hazard2  output  1  a pending write targets R1/R2.

Function
REQ-005 The block SHALL give each requester a 1-entry hold register (valid bit, 5b rd, 32b data).
REQ-006 reqi_ready SHALL be rst_n AND (hold i empty OR hold i granted this cycle); back-to-back acceptance per requester at one per cycle.
REQ-007 An accepted request with rd==0 SHALL be discarded: hold not loaded, no write issued, no hazard raised.
REQ-008 An accepted request with rd!=0 SHALL load hold i at that clock edge.
REQ-009 Each cycle at most one valid hold entry SHALL be granted; a grant clears that hold at the edge unless it is simultaneously reloaded via REQ-006.
REQ-010 On grant, RegWrite/W1/WD1 SHALL be registered from the granted entry at the same edge; with no grant, RegWrite SHALL be 0 next cycle and W1/WD1 SHALL hold their values.
REQ-011 Latency: request accepted at edge N -> RegWrite=1 during cycle N+1..N+2 window, i.e. granted earliest in cycle N+1, RegWrite high in cycle N+2, register file written at edge ending cycle N+2.
REQ-012 Arbitration state SHALL be one bit last_grant; with both holds valid, grant the requester != last_grant; with one valid, grant it; last_grant SHALL update only on a grant.
REQ-013 hazardK SHALL be 1 iff RK!=0 and RK equals rd of any valid hold entry or W1 while RegWrite=1; purely combinational.
REQ-014 Same-rd writes from both requesters SHALL both be issued, in grant order; the later grant's data wins.
REQ-015 Holds SHALL never be overwritten while valid and not granted (no data loss).

Reset
REQ-016 While rst_n=0: both holds empty, RegWrite=0, W1=0, WD1=0, last_grant=1 (requester 0 wins first contention), req0_ready=req1_ready=0, hazard1=hazard2=0.
REQ-017 Reset asserted mid-operation SHALL discard all held and in-flight writes; RegWrite SHALL drop immediately (asynchronously).
REQ-018 The first acceptance after deassertion SHALL occur at the first rising edge with rst_n=1.

Configuration
REQ-019 Macro WBARB_ROUND_ROBIN_EN defined: arbitration per REQ-012.
REQ-020 Macro WBARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins contention, last_grant unused; all other requirements unchanged.

Verification
REQ-021 Single write: req0 rd=5 data=0xDEADBEEF at edge 1 -> RegWrite=1, W1=5, WD1=0xDEADBEEF during cycle 3; hazard1=1 with R1=5 during cycles 2-3.
REQ-022 Contention, round-robin: both valid every cycle, req0 rd=1..4, req1 rd=11..14 -> write order 1,11,2,12,3,13,4,14; each ready low on alternate cycles; no write lost.
REQ-023 Fixed priority (macro undefined), same stimulus -> 1,2,3,4 then 11,12,13,14 (req1 stalls until req0 idle).
REQ-024 x0 drop: req1 rd=0 data=0x1234 -> ready=1, RegWrite stays 0, hazard1=0 with R1=0.
REQ-025 Same-rd: req0 rd=7 data=0xA and req1 rd=7 data=0xB in same cycle -> two writes to 7, 0xA then 0xB.
REQ-026 Reset mid-flight: assert rst_n=0 while both holds valid and RegWrite=1 -> RegWrite=0 immediately; after release, no stale write issued.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Requester, register-file write port and hazard-query bundle for regfile_wb_arbiter.
// The slave modport is the arbiter side and the master modport is the requester/regfile side.
interface regfile_wb_arbiter_if;
  logic        req0_valid;
  logic [4:0]  req0_rd;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_rd;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        RegWrite;
  logic [4:0]  W1;
  logic [31:0] WD1;
  logic [4:0]  R1;
  logic [4:0]  R2;
  logic        hazard1;
  logic        hazard2;

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    input  R1, R2,
    output req0_ready, req1_ready,
    output RegWrite, W1, WD1,
    output hazard1, hazard2
  );

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    output R1, R2,
    input  req0_ready, req1_ready,
    input  RegWrite, W1, WD1,
    input  hazard1, hazard2
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester write-back arbiter with one hold register per requester and RAW hazard flags.
// WBARB_ROUND_ROBIN_EN selects round-robin contention; the default build uses fixed priority to requester 0.
module regfile_wb_arbiter (
  input logic                  clk,
  input logic                  rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  logic        hold0Valid_q, hold0Valid_d;
  logic [4:0]  hold0Rd_q, hold0Rd_d;
  logic [31:0] hold0Data_q, hold0Data_d;
  logic        hold1Valid_q, hold1Valid_d;
  logic [4:0]  hold1Rd_q, hold1Rd_d;
  logic [31:0] hold1Data_q, hold1Data_d;
  logic        regWrite_q, regWrite_d;
  logic [4:0]  w1_q, w1_d;
  logic [31:0] wd1_q, wd1_d;
  logic        grant0, grant1;
  logic        load0, load1;

`ifdef WBARB_ROUND_ROBIN_EN
  logic        lastGrant_q, lastGrant_d;

  // lastGrant_q == 1 means requester 1 won most recently, so requester 0 is favoured next.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (hold0Valid_q && hold1Valid_q) begin
      grant0 = lastGrant_q;
      grant1 = !lastGrant_q;
    end else begin
      grant0 = hold0Valid_q;
      grant1 = hold1Valid_q;
    end
  end

  always_comb begin
    lastGrant_d = lastGrant_q;
    if (grant0) lastGrant_d = 1'b0;
    if (grant1) lastGrant_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lastGrant_q <= 1'b1;
    else        lastGrant_q <= lastGrant_d;
  end
`else
  always_comb begin
    grant0 = hold0Valid_q;
    grant1 = hold1Valid_q && !hold0Valid_q;
  end
`endif

  // A hold can take a new request when it is empty or draining this cycle.
  assign bus.req0_ready = rst_n && (!hold0Valid_q || grant0);
  assign bus.req1_ready = rst_n && (!hold1Valid_q || grant1);

  assign load0 = bus.req0_valid && bus.req0_ready && (bus.req0_rd != 5'd0);
  assign load1 = bus.req1_valid && bus.req1_ready && (bus.req1_rd != 5'd0);

  always_comb begin
    hold0Valid_d = hold0Valid_q;
    hold0Rd_d    = hold0Rd_q;
    hold0Data_d  = hold0Data_q;
    hold1Valid_d = hold1Valid_q;
    hold1Rd_d    = hold1Rd_q;
    hold1Data_d  = hold1Data_q;
    regWrite_d   = grant0 || grant1;
    w1_d         = w1_q;
    wd1_d        = wd1_q;
    if (grant0) begin
      hold0Valid_d = 1'b0;
      w1_d         = hold0Rd_q;
      wd1_d        = hold0Data_q;
    end
    if (grant1) begin
      hold1Valid_d = 1'b0;
      w1_d         = hold1Rd_q;
      wd1_d        = hold1Data_q;
    end
    if (load0) begin
      hold0Valid_d = 1'b1;
      hold0Rd_d    = bus.req0_rd;
      hold0Data_d  = bus.req0_data;
    end
    if (load1) begin
      hold1Valid_d = 1'b1;
      hold1Rd_d    = bus.req1_rd;
      hold1Data_d  = bus.req1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold0Valid_q <= 1'b0;
      hold0Rd_q    <= 5'd0;
      hold0Data_q  <= 32'd0;
      hold1Valid_q <= 1'b0;
      hold1Rd_q    <= 5'd0;
      hold1Data_q  <= 32'd0;
      regWrite_q   <= 1'b0;
      w1_q         <= 5'd0;
      wd1_q        <= 32'd0;
    end else begin
      hold0Valid_q <= hold0Valid_d;
      hold0Rd_q    <= hold0Rd_d;
      hold0Data_q  <= hold0Data_d;
      hold1Valid_q <= hold1Valid_d;
      hold1Rd_q    <= hold1Rd_d;
      hold1Data_q  <= hold1Data_d;
      regWrite_q   <= regWrite_d;
      w1_q         <= w1_d;
      wd1_q        <= wd1_d;
    end
  end

  assign bus.RegWrite = regWrite_q;
  assign bus.W1       = w1_q;
  assign bus.WD1      = wd1_q;

  // A write is pending while it sits in a hold or is on the regfile port this cycle.
  assign bus.hazard1 = (bus.R1 != 5'd0) &&
                       ((hold0Valid_q && hold0Rd_q == bus.R1) ||
                        (hold1Valid_q && hold1Rd_q == bus.R1) ||
                        (regWrite_q && w1_q == bus.R1));
  assign bus.hazard2 = (bus.R2 != 5'd0) &&
                       ((hold0Valid_q && hold0Rd_q == bus.R2) ||
                        (hold1Valid_q && hold1Rd_q == bus.R2) ||
                        (regWrite_q && w1_q == bus.R2));

endmodule
